p2_mem_write: RTL and testbench

Streaming writer for the pooling‑2 output memory: the producer side of the buffer that the P2 read counter sweeps. It accepts the conv‑2 feature map as a raster‑order pixel stream, performs 2×2 max pooling on the fly, and issues one write per pooled result into the 12 × (4×4) P2 memory. It asserts `done` once all 192 results have been written, which releases the downstream read sweep.

---
 rtl/p2_mem_write.sv | 106 ++++++++++
 tb/tb_p2_mem_write.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/p2_mem_write.sv
// Streaming 2x2 max-pool writer for the P2 memory: raster pixels in, one write per pooled result out.
// Optional fused ReLU on the written value is selected with the P2_RELU_EN macro.
module p2_mem_write #(
  parameter int DATA_W   = 16,
  parameter int IN_DIM   = 8,
  parameter int CHANNELS = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [3:0]        wr_chan,
  output logic [DATA_W-1:0] wr_data,
  output logic              done
);

  localparam int RESULTS = CHANNELS * (IN_DIM / 2) * (IN_DIM / 2);

  logic [2:0] col;
  logic [2:0] row;
  logic [3:0] chan;
  logic [7:0] res_cnt;

  logic signed [DATA_W-1:0] pair;
  logic signed [DATA_W-1:0] linebuf [4];
  logic signed [DATA_W-1:0] px;
  logic signed [DATA_W-1:0] lb_rd;
  logic signed [DATA_W-1:0] max_pp;
  logic signed [DATA_W-1:0] result;
  logic signed [DATA_W-1:0] wr_value;

  logic accept;
  logic is_store;
  logic is_write;

  // Handshake: a pixel transfers on a posedge where in_valid && in_ready; the
  // producer holds in_data stable while in_valid is high and in_ready is low.
  assign in_ready = enable && !done && !reset;
  assign accept   = in_valid && in_ready;
  assign is_store = accept && col[0] && !row[0];
  assign is_write = accept && col[0] && row[0];

  always_comb begin
    px       = $signed(in_data);
    lb_rd    = linebuf[col[2:1]];
    max_pp   = (pair > px) ? pair : px;
    result   = (lb_rd > max_pp) ? lb_rd : max_pp;
`ifdef P2_RELU_EN
    wr_value = result[DATA_W-1] ? '0 : result;
`else
    wr_value = result;
`endif
  end

  // Stream position, pair latch, and write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      chan    <= '0;
      res_cnt <= '0;
      pair    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_chan <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (accept) begin
        col <= col + 3'd1;
        if (col == 3'd7) begin
          row <= row + 3'd1;
          if (row == 3'd7) begin
            chan <= (chan == 4'(CHANNELS - 1)) ? 4'd0 : chan + 4'd1;
          end
        end
        if (!col[0]) begin
          pair <= px;
        end
      end
      if (is_write) begin
        wr_en   <= 1'b1;
        wr_data <= wr_value;
        wr_addr <= {row[2:1], col[2:1]};
        wr_chan <= chan;
        res_cnt <= res_cnt + 8'd1;
        if (res_cnt == 8'(RESULTS - 1)) begin
          done <= 1'b1;
        end
      end
    end
  end

  // Line buffer holds the top-row pair maxima; contents are irrelevant after reset.
  always_ff @(posedge clk) begin
    if (is_store) begin
      linebuf[col[2:1]] <= max_pp;
    end
  end

endmodule

// File: tb/tb_p2_mem_write.sv
// Scoreboard bench for p2_mem_write: driver pushes expected writes, a negedge monitor pops and compares.
module tb_p2_mem_write;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_chan;
  logic [15:0] wr_data;
  logic        done;

  p2_mem_write #(.DATA_W(16), .IN_DIM(8), .CHANNELS(12)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_chan  (wr_chan),
    .wr_data  (wr_data),
    .done     (done)
  );

`ifdef P2_RELU_EN
  localparam logic [15:0] NEG_WIN_EXP = 16'h0000;
`else
  localparam logic [15:0] NEG_WIN_EXP = 16'hFFFE;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] exp_q [$];
  logic [23:0] hist_q [$];
  logic [15:0] img [768];
  logic [15:0] wlog [256];
  logic        exp_wr = 1'b0;
  int          n_writes = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] win_max(input int base);
    logic signed [15:0] m;
    int idx [3];
    idx[0] = base + 1;
    idx[1] = base + 8;
    idx[2] = base + 9;
    m = $signed(img[base]);
    for (int k = 0; k < 3; k++) begin
      if ($signed(img[idx[k]]) > m) m = $signed(img[idx[k]]);
    end
`ifdef P2_RELU_EN
    if (m < 0) m = 16'sd0;
`endif
    return m;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_wr = 1'b0;
    reset = 1'b0;
  endtask

  // Driver: streams img[0..n_pix-1]; gaps mix valid-low idles and enable-low stalls.
  task automatic send_frame(input int max_gap, input int n_pix);
    for (int p = 0; p < n_pix; p++) begin
      int g;
      int col;
      int row;
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      if (max_gap > 0 && p == 8 && g < 2) g = 2;
      for (int i = 0; i < g; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          in_valid = 1'b1; enable = 1'b0; in_data = img[p];
        end else begin
          in_valid = 1'b0; enable = 1'b1; in_data = 16'($urandom);
        end
        @(posedge clk); #1;
        exp_wr = 1'b0;
      end
      in_valid = 1'b1; enable = 1'b1; in_data = img[p];
      @(posedge clk); #1;
      col = p % 8;
      row = (p / 8) % 8;
      if ((col % 2 == 1) && (row % 2 == 1)) begin
        exp_q.push_back({4'(p / 64), 4'((row / 2) * 4 + col / 2), win_max(p - 9)});
        exp_wr = 1'b1;
      end else begin
        exp_wr = 1'b0;
      end
      in_valid = 1'b0;
      chk(done == (p == 767), "done_timing", 32'(done), 32'(p == 767));
    end
  endtask

  // Monitor: checks strobe timing every cycle and pops the scoreboard on each write.
  always @(negedge clk) begin
    chk(wr_en == exp_wr, "wr_en_timing", 32'(wr_en), 32'(exp_wr));
    if (wr_en) begin
      n_writes++;
      hist_q.push_back({wr_chan, wr_addr, wr_data});
      wlog[{wr_chan, wr_addr}] = wr_data;
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_write", {8'h0, wr_chan, wr_addr, wr_data}, 32'h0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk({wr_chan, wr_addr, wr_data} == e, "write_value", {8'h0, wr_chan, wr_addr, wr_data}, {8'h0, e});
      end
    end
  end

  initial begin
    int w0;
    int h0;
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0;
    #1;
    chk(in_ready == 1'b0, "ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk(wr_en == 1'b0, "rst_wr_en", 32'(wr_en), 32'd0);
    chk(wr_addr == 4'd0, "rst_wr_addr", 32'(wr_addr), 32'd0);
    chk(wr_chan == 4'd0, "rst_wr_chan", 32'(wr_chan), 32'd0);
    chk(wr_data == 16'd0, "rst_wr_data", 32'(wr_data), 32'd0);
    chk(done == 1'b0, "rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    #1;
    chk(in_ready == 1'b1, "ready_after_reset", 32'(in_ready), 32'd1);

    // Ramp stream, continuous.
    for (int p = 0; p < 768; p++) img[p] = 16'(p);
    w0 = n_writes;
    send_frame(0, 768);
    @(negedge clk); #1;
    chk(n_writes - w0 == 192, "ramp_write_count", 32'(n_writes - w0), 32'd192);
    chk(exp_q.size() == 0, "ramp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk(wlog[0] == 16'd9, "ramp_c0_a0", 32'(wlog[0]), 32'd9);
    chk(wlog[15] == 16'd63, "ramp_c0_a15", 32'(wlog[15]), 32'd63);
    chk(wlog[11 * 16 + 15] == 16'd767, "ramp_c11_a15", 32'(wlog[11 * 16 + 15]), 32'd767);

    // Pixels after done are ignored.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; enable = 1'b1; in_data = 16'($urandom);
      #1;
      chk(in_ready == 1'b0, "ready_after_done", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      exp_wr = 1'b0;
      chk(done == 1'b1, "done_sticky", 32'(done), 32'd1);
    end
    in_valid = 1'b0;
    do_reset();
    chk(done == 1'b0, "done_cleared", 32'(done), 32'd0);

    // Signed pattern with an all-negative first window, streamed with gaps.
    for (int p = 0; p < 768; p++) img[p] = 16'((p * 37) % 201 - 100);
    img[0] = -16'sd5; img[1] = -16'sd2; img[8] = -16'sd7; img[9] = -16'sd3;
    w0 = n_writes;
    send_frame(3, 768);
    @(negedge clk); #1;
    chk(n_writes - w0 == 192, "gap_write_count", 32'(n_writes - w0), 32'd192);
    chk(wlog[0] == NEG_WIN_EXP, "neg_window", 32'(wlog[0]), 32'(NEG_WIN_EXP));
    do_reset();

    // Reset on the edge of accept 300 (an odd/odd pixel), then a fresh frame.
    for (int p = 0; p < 768; p++) img[p] = 16'(p);
    send_frame(0, 299);
    in_valid = 1'b1; enable = 1'b1; in_data = img[299]; reset = 1'b1;
    @(posedge clk); #1;
    exp_wr = 1'b0;
    reset = 1'b0; in_valid = 1'b0;
    chk(wr_addr == 4'd0, "midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk(wr_data == 16'd0, "midrst_wr_data", 32'(wr_data), 32'd0);
    chk(done == 1'b0, "midrst_done", 32'(done), 32'd0);
    chk(exp_q.size() == 0, "midrst_queue_empty", 32'(exp_q.size()), 32'd0);
    w0 = n_writes;
    h0 = hist_q.size();
    send_frame(0, 768);
    @(negedge clk); #1;
    chk(n_writes - w0 == 192, "fresh_write_count", 32'(n_writes - w0), 32'd192);
    if (hist_q.size() > h0) begin
      chk(hist_q[h0] == {4'd0, 4'd0, 16'd9}, "fresh_first_write", 32'(hist_q[h0]), 32'h0009);
    end else begin
      chk(1'b0, "fresh_first_write_missing", 32'(hist_q.size()), 32'(h0 + 1));
    end
    do_reset();
    chk(done == 1'b0, "final_done_cleared", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
